// File: rtl/riscv_pkg.sv
// Shared types for the register-file write path: the write request record,
// the write-arbiter state encoding and register-address width constants.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  // Widest register data the shared write record can carry; users narrow it.
  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned CNT_W      = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_MAX-1:0]   data;
  } wr_req_t;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (fixed
// priority) and the long-latency unit, with a starvation-driven forced slot.
module regfile_write_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  wb_ready_o,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_rd_i,
  input  logic [XLEN-1:0]       lu_data_i,
  output logic                  lu_ready_o,
  output logic                  wr_reg_en_o,
  output logic [REG_ADDR_W-1:0] wr_rd_o,
  output logic [XLEN-1:0]       wr_data_o,
  output logic                  stall_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_inc;
  wr_req_t          wr_q, wr_d;
  logic             wb_req, lu_req;

  // x0 destinations are accepted but never become real requests.
  assign wb_req = wb_valid_i && (wb_rd_i != '0);
  assign lu_req = lu_valid_i && (lu_rd_i != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_NORMAL;
      wait_cnt_q <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_q       <= wr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = S_NORMAL;
    wait_cnt_d   = wait_cnt_q;
    wr_d         = '0;
    wait_cnt_inc = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

    unique case (state_q)
      S_NORMAL: begin
        if (wb_req) begin
          wr_d.valid = 1'b1;
          wr_d.rd    = wb_rd_i;
          wr_d.data  = XLEN_MAX'(wb_data_i);
        end else if (lu_req) begin
          wr_d.valid = 1'b1;
          wr_d.rd    = lu_rd_i;
          wr_d.data  = XLEN_MAX'(lu_data_i);
        end

        // Denied only when a real WB write takes the port; an x0 WB never blocks.
        if (lu_valid_i && wb_req) begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == LIMIT) state_d = S_FORCE;
        end else if (lu_valid_i) begin
          wait_cnt_d = '0;
        end
      end

      S_FORCE: begin
        if (lu_req) begin
          wr_d.valid = 1'b1;
          wr_d.rd    = lu_rd_i;
          wr_d.data  = XLEN_MAX'(lu_data_i);
        end
        wait_cnt_d = '0;
      end

      default: ;
    endcase
  end

  // Handshake outputs depend only on state and live inputs; reset holds
  // state_q at S_NORMAL, which gives the required in-reset ready values.
  always_comb begin
    stall_o    = 1'b0;
    wb_ready_o = 1'b1;
    lu_ready_o = lu_valid_i && !wb_req;
    if (state_q == S_FORCE) begin
      stall_o    = 1'b1;
      wb_ready_o = 1'b0;
      lu_ready_o = lu_valid_i;
    end
  end

  assign wr_reg_en_o = wr_q.valid;
  assign wr_rd_o     = wr_q.rd;
  assign wr_data_o   = XLEN'(wr_q.data);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// reset-in-force sequence, and randomized traffic against a reference model.
module tb_regfile_write_arbiter;

  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            wb_ready_o;
  logic            lu_valid_i;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            lu_ready_o;
  logic            wr_reg_en_o;
  logic [4:0]      wr_rd_o;
  logic [XLEN-1:0] wr_data_o;
  logic            stall_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  regfile_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .wb_ready_o (wb_ready_o),
    .lu_valid_i (lu_valid_i),
    .lu_rd_i    (lu_rd_i),
    .lu_data_i  (lu_data_i),
    .lu_ready_o (lu_ready_o),
    .wr_reg_en_o(wr_reg_en_o),
    .wr_rd_o    (wr_rd_o),
    .wr_data_o  (wr_data_o),
    .stall_o    (stall_o)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  wrd;
    logic [63:0] wd;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        e_wbr;
    logic        e_lur;
    logic        e_stall;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wv, input logic [4:0] wrd, input logic [63:0] wd,
                              input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                              input logic e_wbr, input logic e_lur, input logic e_stall,
                              input logic e_en, input logic [4:0] e_rd, input logic [63:0] e_data);
    vec_t v;
    v.wv = wv; v.wrd = wrd; v.wd = wd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.e_wbr = e_wbr; v.e_lur = e_lur; v.e_stall = e_stall;
    v.e_en = e_en; v.e_rd = e_rd; v.e_data = e_data;
    return v;
  endfunction

  task automatic set_inputs(input logic wv, input logic [4:0] wrd, input logic [63:0] wd,
                            input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reference-model state for the random phase.
    logic        m_force;
    int          m_denied;
    logic        e_en, e_stall, e_wbr, e_lur;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        wb_req, lu_req;
    logic        prev_lu_acc, prev_stall;
    int          lu_age;

    rst_ni = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_wr_en",    wr_reg_en_o, 0);
    check("reset_wr_rd",    wr_rd_o,     0);
    check("reset_wr_data",  wr_data_o,   0);
    check("reset_stall",    stall_o,     0);
    check("reset_wb_ready", wb_ready_o,  1);
    check("reset_lu_ready", lu_ready_o,  0);
    lu_valid_i = 1'b1; lu_rd_i = 5'd4;
    #1;
    check("reset_lu_ready_eq", lu_ready_o, 1);
    lu_valid_i = 1'b0; lu_rd_i = 5'd0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed vectors, starting from wait_cnt = 0 in S_NORMAL.
    vecs.push_back(mk(0, 0, 64'h0,   1, 5, 64'hDEAD, 1, 1, 0, 1, 5, 64'hDEAD));
    vecs.push_back(mk(1, 0, 64'h1,   1, 9, 64'h99,   1, 1, 0, 1, 9, 64'h99));
    vecs.push_back(mk(1, 0, 64'h1,   0, 0, 64'h0,    1, 0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 64'h0,   1, 0, 64'h55,   1, 1, 0, 0, 0, 64'h0));
    for (int i = 0; i < LIMIT; i++)
      vecs.push_back(mk(1, 3, 64'h333, 1, 7, 64'h777, 1, 0, 0, 1, 3, 64'h333));
    vecs.push_back(mk(1, 3, 64'h333, 1, 7, 64'h777, 0, 1, 1, 1, 7, 64'h777));
    for (int i = 0; i < LIMIT; i++)
      vecs.push_back(mk(1, 3, 64'h333, 1, 7, 64'h778, 1, 0, 0, 1, 3, 64'h333));
    vecs.push_back(mk(1, 3, 64'h333, 1, 7, 64'h778, 0, 1, 1, 1, 7, 64'h778));
    vecs.push_back(mk(1, 3, 64'h333, 0, 0, 64'h0,   1, 0, 0, 1, 3, 64'h333));
    vecs.push_back(mk(0, 0, 64'h0,   0, 0, 64'h0,   1, 0, 0, 0, 0, 64'h0));

    foreach (vecs[i]) begin
      set_inputs(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      #1;
      check($sformatf("vec%0d_wb_ready", i), wb_ready_o, vecs[i].e_wbr);
      check($sformatf("vec%0d_lu_ready", i), lu_ready_o, vecs[i].e_lur);
      check($sformatf("vec%0d_stall", i),    stall_o,    vecs[i].e_stall);
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_wr_en", i), wr_reg_en_o, vecs[i].e_en);
      if (vecs[i].e_en) begin
        check($sformatf("vec%0d_wr_rd", i),   wr_rd_o,   vecs[i].e_rd);
        check($sformatf("vec%0d_wr_data", i), wr_data_o, vecs[i].e_data);
      end
    end

    // Reach S_FORCE, then reset asynchronously in the middle of the cycle.
    set_inputs(1, 3, 64'h333, 1, 7, 64'h777);
    for (int i = 0; i < LIMIT; i++) begin
      @(posedge clk_i); #1;
    end
    check("pre_rst_stall", stall_o, 1);
    check("pre_rst_wr_en", wr_reg_en_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_stall",    stall_o,     0);
    check("async_rst_wr_en",    wr_reg_en_o, 0);
    check("async_rst_wr_rd",    wr_rd_o,     0);
    check("async_rst_wb_ready", wb_ready_o,  1);
    check("async_rst_lu_ready", lu_ready_o,  0);
    @(posedge clk_i); #1;
    check("rst_held_wr_en", wr_reg_en_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k <= LIMIT + 1; k++) begin
      #1;
      check($sformatf("rearb%0d_stall", k),    stall_o,    (k == LIMIT) ? 1 : 0);
      check($sformatf("rearb%0d_lu_ready", k), lu_ready_o, (k == LIMIT) ? 1 : 0);
      if (k == LIMIT + 1) begin
        check("rearb_wr_rd",   wr_rd_o,   7);
        check("rearb_wr_data", wr_data_o, 64'h777);
      end
      @(posedge clk_i);
    end

    // Randomized traffic against the reference model.
    #1;
    rst_ni = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    m_force = 1'b0; m_denied = 0;
    e_en = 1'b0; e_rd = '0; e_data = '0;
    prev_lu_acc = 1'b1; prev_stall = 1'b0; lu_age = 0;

    for (int c = 0; c < 3000; c++) begin
      if (!prev_stall) begin
        wb_valid_i = ($urandom_range(0, 3) != 0);
        wb_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data_i  = {$urandom, $urandom};
      end
      if (prev_lu_acc || !lu_valid_i) begin
        lu_valid_i = ($urandom_range(0, 2) == 0);
        lu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lu_data_i  = {$urandom, $urandom};
        lu_age     = 0;
      end
      #1;

      wb_req = wb_valid_i && (wb_rd_i != 0);
      lu_req = lu_valid_i && (lu_rd_i != 0);
      e_en = 1'b0; e_rd = '0; e_data = '0;
      if (m_force) begin
        e_stall = 1'b1; e_wbr = 1'b0; e_lur = lu_valid_i;
        if (lu_req) begin e_en = 1'b1; e_rd = lu_rd_i; e_data = lu_data_i; end
        m_force = 1'b0; m_denied = 0;
      end else begin
        e_stall = 1'b0; e_wbr = 1'b1; e_lur = lu_valid_i && !wb_req;
        if (wb_req) begin
          e_en = 1'b1; e_rd = wb_rd_i; e_data = wb_data_i;
        end else if (lu_req) begin
          e_en = 1'b1; e_rd = lu_rd_i; e_data = lu_data_i;
        end
        if (lu_valid_i && wb_req) begin
          m_denied++;
          if (m_denied == LIMIT) m_force = 1'b1;
        end else if (lu_valid_i) begin
          m_denied = 0;
        end
      end

      check("rand_stall",    stall_o,    e_stall);
      check("rand_wb_ready", wb_ready_o, e_wbr);
      check("rand_lu_ready", lu_ready_o, e_lur);

      prev_lu_acc = lu_valid_i && lu_ready_o;
      prev_stall  = stall_o;
      if (lu_valid_i && !lu_ready_o) lu_age++;
      if (prev_lu_acc && lu_age > LIMIT)
        check("rand_lu_wait_bound", lu_age, LIMIT);

      @(posedge clk_i); #1;
      check("rand_wr_en", wr_reg_en_o, e_en);
      if (e_en) begin
        check("rand_wr_rd",   wr_rd_o,   e_rd);
        check("rand_wr_data", wr_data_o, e_data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
